// File: rtl/dcpu16_pkg.sv
// Shared definitions for the DCPU16 arithmetic sequencer: opcodes, FSM
// state encoding and divider iteration defaults.
package dcpu16_pkg;

    localparam logic [3:0] OPC_ILL = 4'h0;
    localparam logic [3:0] OPC_SET = 4'h1;
    localparam logic [3:0] OPC_ADD = 4'h2;
    localparam logic [3:0] OPC_SUB = 4'h3;
    localparam logic [3:0] OPC_MUL = 4'h4;
    localparam logic [3:0] OPC_DIV = 4'h5;
    localparam logic [3:0] OPC_MOD = 4'h6;
    localparam logic [3:0] OPC_SHL = 4'h7;
    localparam logic [3:0] OPC_SHR = 4'h8;
    localparam logic [3:0] OPC_AND = 4'h9;
    localparam logic [3:0] OPC_BOR = 4'hA;
    localparam logic [3:0] OPC_XOR = 4'hB;
    localparam logic [3:0] OPC_IFE = 4'hC;
    localparam logic [3:0] OPC_IFN = 4'hD;
    localparam logic [3:0] OPC_IFG = 4'hE;
    localparam logic [3:0] OPC_IFB = 4'hF;

    localparam int DIV_STEPS_DEF = 32;
    localparam int MOD_STEPS_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dcpu16_divu.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// done/quot/rem present the result of the step taken on the edge where done is high.
module dcpu16_divu #(
    parameter int DW = 16,
    parameter int CW = $clog2(2 * DW + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2*DW-1:0]   dividend,
    input  logic [DW-1:0]     divisor,
    input  logic [CW-1:0]     nsteps,
    output logic              done,
    output logic [2*DW-1:0]   quot,
    output logic [DW-1:0]     rem
);

    logic              busy_r;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     nsteps_r;
    logic [2*DW-1:0]   dvd_r;
    logic [DW-1:0]     dvs_r;
    logic [2*DW-2:0]   quot_r;
    logic [DW-1:0]     rem_r;

    logic [DW:0]       trial_s;
    logic [DW:0]       diff_s;
    logic              ge_s;
    logic [DW-1:0]     rem_nxt_s;
    logic [2*DW-1:0]   quot_nxt_s;
    logic              done_s;

    // Trial subtraction; the partial remainder stays below the divisor, so the
    // borrow bit of the difference is exactly "trial < divisor".
    always_comb begin
        trial_s    = {rem_r, dvd_r[2*DW-1]};
        diff_s     = trial_s - {1'b0, dvs_r};
        ge_s       = ~diff_s[DW];
        if (ge_s) begin
            rem_nxt_s = diff_s[DW-1:0];
        end else begin
            rem_nxt_s = trial_s[DW-1:0];
        end
        quot_nxt_s = {quot_r, ge_s};
        done_s     = busy_r && (cnt_r == (nsteps_r - {{(CW-1){1'b0}}, 1'b1}));
    end

    assign done = done_s;
    assign quot = quot_nxt_s;
    assign rem  = rem_nxt_s;

    // Operand load on start, then one shift/subtract step per cycle while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r   <= 1'b0;
            cnt_r    <= '0;
            nsteps_r <= '0;
            dvd_r    <= '0;
            dvs_r    <= '0;
            quot_r   <= '0;
            rem_r    <= '0;
        end else if (start) begin
            busy_r   <= 1'b1;
            cnt_r    <= '0;
            nsteps_r <= nsteps;
            dvd_r    <= dividend;
            dvs_r    <= divisor;
            quot_r   <= '0;
            rem_r    <= '0;
        end else if (busy_r) begin
            dvd_r    <= {dvd_r[2*DW-2:0], 1'b0};
            rem_r    <= rem_nxt_s;
            quot_r   <= quot_nxt_s[2*DW-2:0];
            cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            busy_r   <= ~done_s;
        end else begin
            busy_r   <= 1'b0;
        end
    end

endmodule

// File: rtl/dcpu16_alu_seq.sv
// DCPU16 ALU sequencer: request/response handshake, single-cycle ops,
// DIV/MOD through the iterative divider, IFx evaluation and the O register.
module dcpu16_alu_seq
    import dcpu16_pkg::*;
#(
    parameter int DW        = 16,
    parameter int DIV_STEPS = DIV_STEPS_DEF,
    parameter int MOD_STEPS = MOD_STEPS_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_vld,
    output logic          req_rdy,
    input  logic [3:0]    req_opc,
    input  logic [15:0]   req_a,
    input  logic [15:0]   req_b,
    output logic          rsp_vld,
    input  logic          rsp_rdy,
    output logic [15:0]   rsp_res,
    output logic          rsp_wre,
    output logic          rsp_skp,
    output logic          rsp_err,
    output logic [15:0]   reg_o,
    output logic          busy
);

    localparam int CW = $clog2(2 * DW + 1);

    state_t        state_r, state_nxt_s;
    logic [3:0]    opc_r, opc_nxt_s;
    logic [15:0]   rsp_res_r, res_nxt_s;
    logic          rsp_wre_r, wre_nxt_s;
    logic          rsp_skp_r, skp_nxt_s;
    logic          rsp_err_r, err_nxt_s;
    logic [15:0]   reg_o_r, o_nxt_s;
    logic          rsp_vld_r, req_rdy_r, busy_r;

    logic [16:0]   sum_s;
    logic [31:0]   mul_s;
    logic [31:0]   shl_s;
    logic [15:0]   shr_o_s;
    logic          b_ge16_s, b_ge32_s;

    logic [15:0]   alu_res_s, alu_o_s;
    logic          alu_wre_s, alu_skp_s, alu_err_s, alu_iter_s;

    logic          div_start_s, div_done_s;
    logic [CW-1:0] div_nsteps_s;
    logic [31:0]   div_quot_s;
    logic [15:0]   div_rem_s;

    assign sum_s    = {1'b0, req_a} + {1'b0, req_b};
    assign mul_s    = {16'h0000, req_a} * {16'h0000, req_b};
    assign shl_s    = {16'h0000, req_a} << req_b[4:0];
    assign shr_o_s  = 16'(({req_a, 16'h0000}) >> req_b[4:0]);
    assign b_ge16_s = |req_b[15:4];
    assign b_ge32_s = |req_b[15:5];

    // Result of the single-cycle ops from the request operands; DIV/MOD with a
    // non-zero divisor instead flag that the divider has to run.
    always_comb begin
        alu_res_s  = 16'h0000;
        alu_o_s    = reg_o_r;
        alu_wre_s  = 1'b0;
        alu_skp_s  = 1'b0;
        alu_err_s  = 1'b0;
        alu_iter_s = 1'b0;
        case (req_opc)
            OPC_SET: begin
                alu_res_s = req_b;
                alu_wre_s = 1'b1;
            end
            OPC_ADD: begin
                alu_res_s = sum_s[15:0];
                alu_o_s   = {15'h0000, sum_s[16]};
                alu_wre_s = 1'b1;
            end
            OPC_SUB: begin
                alu_res_s = req_a - req_b;
                alu_o_s   = (req_b > req_a) ? 16'hFFFF : 16'h0000;
                alu_wre_s = 1'b1;
            end
            OPC_MUL: begin
                alu_res_s = mul_s[15:0];
                alu_o_s   = mul_s[31:16];
                alu_wre_s = 1'b1;
            end
            OPC_DIV: begin
                alu_wre_s = 1'b1;
                if (req_b == 16'h0000) begin
                    alu_o_s = 16'h0000;
                end else begin
                    alu_iter_s = 1'b1;
                end
            end
            OPC_MOD: begin
                alu_wre_s = 1'b1;
                if (req_b == 16'h0000) begin
                    alu_res_s = 16'h0000;
                end else begin
                    alu_iter_s = 1'b1;
                end
            end
            OPC_SHL: begin
                alu_wre_s = 1'b1;
                if (b_ge32_s) begin
                    alu_o_s = 16'h0000;
                end else begin
                    alu_res_s = shl_s[15:0];
                    alu_o_s   = shl_s[31:16];
                end
            end
            OPC_SHR: begin
                alu_wre_s = 1'b1;
                if (b_ge16_s) begin
                    alu_res_s = 16'h0000;
                end else begin
                    alu_res_s = req_a >> req_b[3:0];
                end
                if (b_ge32_s) begin
                    alu_o_s = 16'h0000;
                end else begin
                    alu_o_s = shr_o_s;
                end
            end
            OPC_AND: begin
                alu_res_s = req_a & req_b;
                alu_wre_s = 1'b1;
            end
            OPC_BOR: begin
                alu_res_s = req_a | req_b;
                alu_wre_s = 1'b1;
            end
            OPC_XOR: begin
                alu_res_s = req_a ^ req_b;
                alu_wre_s = 1'b1;
            end
            OPC_IFE: alu_skp_s = ~(req_a == req_b);
            OPC_IFN: alu_skp_s = ~(req_a != req_b);
            OPC_IFG: alu_skp_s = ~(req_a > req_b);
            OPC_IFB: alu_skp_s = ~((req_a & req_b) != 16'h0000);
            default: alu_err_s = 1'b1;
        endcase
    end

    assign div_nsteps_s = (req_opc == OPC_DIV) ? CW'(DIV_STEPS) : CW'(MOD_STEPS);

    dcpu16_divu #(
        .DW (DW),
        .CW (CW)
    ) u_divu (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_s),
        .dividend ({req_a, 16'h0000}),
        .divisor  (req_b),
        .nsteps   (div_nsteps_s),
        .done     (div_done_s),
        .quot     (div_quot_s),
        .rem      (div_rem_s)
    );

    // Next-state and next response/O values; response fields only move on
    // entry to DONE so they stay stable under backpressure.
    always_comb begin
        state_nxt_s = state_r;
        opc_nxt_s   = opc_r;
        res_nxt_s   = rsp_res_r;
        wre_nxt_s   = rsp_wre_r;
        skp_nxt_s   = rsp_skp_r;
        err_nxt_s   = rsp_err_r;
        o_nxt_s     = reg_o_r;
        div_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_vld) begin
                    opc_nxt_s = req_opc;
                    if (alu_iter_s) begin
                        div_start_s = 1'b1;
                        state_nxt_s = ST_ITER;
                    end else begin
                        state_nxt_s = ST_DONE;
                        res_nxt_s   = alu_res_s;
                        wre_nxt_s   = alu_wre_s;
                        skp_nxt_s   = alu_skp_s;
                        err_nxt_s   = alu_err_s;
                        o_nxt_s     = alu_o_s;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (div_done_s) begin
                    state_nxt_s = ST_DONE;
                    wre_nxt_s   = 1'b1;
                    skp_nxt_s   = 1'b0;
                    err_nxt_s   = 1'b0;
                    if (opc_r == OPC_DIV) begin
                        res_nxt_s = div_quot_s[31:16];
                        o_nxt_s   = div_quot_s[15:0];
                    end else begin
                        res_nxt_s = div_rem_s;
                    end
                end else begin
                    state_nxt_s = ST_ITER;
                end
            end
            ST_DONE: begin
                if (rsp_rdy) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, response and O registers; handshake flags registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            opc_r     <= 4'h0;
            rsp_res_r <= 16'h0000;
            rsp_wre_r <= 1'b0;
            rsp_skp_r <= 1'b0;
            rsp_err_r <= 1'b0;
            reg_o_r   <= 16'h0000;
            rsp_vld_r <= 1'b0;
            req_rdy_r <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            opc_r     <= opc_nxt_s;
            rsp_res_r <= res_nxt_s;
            rsp_wre_r <= wre_nxt_s;
            rsp_skp_r <= skp_nxt_s;
            rsp_err_r <= err_nxt_s;
            reg_o_r   <= o_nxt_s;
            rsp_vld_r <= (state_nxt_s == ST_DONE);
            req_rdy_r <= (state_nxt_s == ST_IDLE);
            busy_r    <= (state_nxt_s != ST_IDLE);
        end
    end

    assign req_rdy = req_rdy_r;
    assign rsp_vld = rsp_vld_r;
    assign rsp_res = rsp_res_r;
    assign rsp_wre = rsp_wre_r;
    assign rsp_skp = rsp_skp_r;
    assign rsp_err = rsp_err_r;
    assign reg_o   = reg_o_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_dcpu16_alu_seq.sv
// Directed, table-driven bench for dcpu16_alu_seq with hand-computed results,
// plus backpressure and mid-divide reset sequences.
module tb_dcpu16_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld;
    logic        req_rdy;
    logic [3:0]  req_opc;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [15:0] rsp_res;
    logic        rsp_wre;
    logic        rsp_skp;
    logic        rsp_err;
    logic [15:0] reg_o;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [15:0] o;
        logic        wre;
        logic        skp;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[26];

    dcpu16_alu_seq dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_rdy (req_rdy),
        .req_opc (req_opc),
        .req_a   (req_a),
        .req_b   (req_b),
        .rsp_vld (rsp_vld),
        .rsp_rdy (rsp_rdy),
        .rsp_res (rsp_res),
        .rsp_wre (rsp_wre),
        .rsp_skp (rsp_skp),
        .rsp_err (rsp_err),
        .reg_o   (reg_o),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [3:0] opc, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] res, input logic [15:0] o,
                           input logic wre, input logic skp, input logic err, input int lat);
        vecs[i].opc = opc; vecs[i].a = a; vecs[i].b = b; vecs[i].res = res; vecs[i].o = o;
        vecs[i].wre = wre; vecs[i].skp = skp; vecs[i].err = err; vecs[i].lat = lat;
    endtask

    // Issue one request, measure latency to rsp_vld, check the response, complete it.
    task automatic run_vec(input int i);
        int lat;
        string tag;
        tag = $sformatf("v%0d", i);
        req_opc = vecs[i].opc;
        req_a   = vecs[i].a;
        req_b   = vecs[i].b;
        req_vld = 1'b1;
        @(posedge clk); #1;
        req_vld = 1'b0;
        req_opc = 4'($urandom);
        req_a   = 16'($urandom);
        req_b   = 16'($urandom);
        lat = 1;
        while (!rsp_vld && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " lat"}, 32'(lat), 32'(vecs[i].lat));
        chk({tag, " res"}, {16'h0, rsp_res}, {16'h0, vecs[i].res});
        chk({tag, " o"},   {16'h0, reg_o},   {16'h0, vecs[i].o});
        chk({tag, " wre/skp/err"}, {29'h0, rsp_wre, rsp_skp, rsp_err},
            {29'h0, vecs[i].wre, vecs[i].skp, vecs[i].err});
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
        chk({tag, " idle"}, {30'h0, req_rdy, rsp_vld}, {30'h0, 1'b1, 1'b0});
    endtask

    initial begin
        rst = 1'b1; req_vld = 1'b0; rsp_rdy = 1'b0;
        req_opc = 4'h0; req_a = 16'h0; req_b = 16'h0;

        //        idx opc    a        b        res      o        wre   skp   err   lat
        set_vec( 0, 4'h2, 16'hFFFF, 16'h0002, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1);
        set_vec( 1, 4'h3, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1);
        set_vec( 2, 4'h5, 16'h0007, 16'h0002, 16'h0003, 16'h8000, 1'b1, 1'b0, 1'b0, 33);
        set_vec( 3, 4'h6, 16'h0007, 16'h0002, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0, 17);
        set_vec( 4, 4'h5, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1);
        set_vec( 5, 4'h2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1);
        set_vec( 6, 4'h6, 16'h0005, 16'h0000, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1);
        set_vec( 7, 4'h7, 16'h8001, 16'h0004, 16'h0010, 16'h0008, 1'b1, 1'b0, 1'b0, 1);
        set_vec( 8, 4'h8, 16'h8001, 16'h0004, 16'h0800, 16'h1000, 1'b1, 1'b0, 1'b0, 1);
        set_vec( 9, 4'h7, 16'h8001, 16'h0028, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1);
        set_vec(10, 4'h3, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1);
        set_vec(11, 4'hE, 16'h0005, 16'h0003, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1);
        set_vec(12, 4'hC, 16'h0005, 16'h0003, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1);
        set_vec(13, 4'hF, 16'h00F0, 16'h000F, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1);
        set_vec(14, 4'hD, 16'h0005, 16'h0003, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1);
        set_vec(15, 4'h1, 16'h0001, 16'hBEEF, 16'hBEEF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1);
        set_vec(16, 4'h9, 16'hF0F0, 16'hFF00, 16'hF000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1);
        set_vec(17, 4'hA, 16'hF0F0, 16'hFF00, 16'hFFF0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1);
        set_vec(18, 4'hB, 16'hF0F0, 16'hFF00, 16'h0FF0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1);
        set_vec(19, 4'h0, 16'h0001, 16'h0002, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1);
        set_vec(20, 4'h8, 16'h8001, 16'h0014, 16'h0000, 16'h0800, 1'b1, 1'b0, 1'b0, 1);
        set_vec(21, 4'h5, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 33);
        set_vec(22, 4'h6, 16'hFFFF, 16'h0010, 16'h000F, 16'h0000, 1'b1, 1'b0, 1'b0, 17);
        set_vec(23, 4'h7, 16'h0001, 16'h000F, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0, 1);
        set_vec(24, 4'h7, 16'h0001, 16'h0010, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1);
        set_vec(25, 4'h8, 16'hFFFF, 16'h0010, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("reset outs", {12'h0, rsp_vld, req_rdy, busy, rsp_wre, rsp_skp, rsp_err, rsp_res},
            {12'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
        chk("reset o", {16'h0, reg_o}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 26; i++) begin
            run_vec(i);
        end

        // Backpressure on a MUL response: outputs stable, no new accept.
        req_opc = 4'h4; req_a = 16'h1234; req_b = 16'h5678; req_vld = 1'b1;
        @(posedge clk); #1;
        req_opc = 4'h2; req_a = 16'h1111; req_b = 16'h2222;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d vld/rdy/busy", c), {29'h0, rsp_vld, req_rdy, busy}, {29'h0, 3'b101});
            chk($sformatf("bp%0d res", c), {16'h0, rsp_res}, 32'h0060);
            chk($sformatf("bp%0d o", c), {16'h0, reg_o}, 32'h0626);
            @(posedge clk); #1;
        end
        req_vld = 1'b0;
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
        chk("bp release", {30'h0, rsp_vld, req_rdy}, {30'h0, 2'b01});

        // Reset ten cycles into a DIV: aborts with no response and clears O.
        req_opc = 4'h5; req_a = 16'h0007; req_b = 16'h0002; req_vld = 1'b1;
        @(posedge clk); #1;
        req_vld = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("div busy pre-rst", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst abort state", {29'h0, busy, req_rdy, rsp_vld}, {29'h0, 3'b010});
        chk("rst abort o", {16'h0, reg_o}, 32'h0);
        begin
            int seen;
            seen = 0;
            rsp_rdy = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk); #1;
                if (rsp_vld) seen++;
            end
            rsp_rdy = 1'b0;
            chk("no rsp after rst", 32'(seen), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
